// File: rtl/max_scan_pkg.sv
// Shared types and default widths for the burst-maximum sequencer.
package max_scan_pkg;

  localparam int DATA_W = 8;
  localparam int LEN_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/max_cmp.sv
// Unsigned strict greater-than comparator shared by the scan sequencer.
module max_cmp #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              gt
);

  assign gt = (a > b);

endmodule

// File: rtl/max_scan_ctrl.sv
// Sequences a burst of operands through one comparator, tracking the maximum
// and the index of its first occurrence, then holds the result until accepted.
module max_scan_ctrl
  import max_scan_pkg::*;
#(
  parameter int DATA_W = max_scan_pkg::DATA_W,
  parameter int LEN_W  = max_scan_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_max,
  output logic [LEN_W-1:0]  out_idx,
  output logic              busy,
  output logic              err
);

  state_e             state;
  logic [LEN_W-1:0]   cnt;
  logic [LEN_W-1:0]   len_q;
  logic               gt;
  logic               last_beat;

  max_cmp #(.DATA_W(DATA_W)) u_cmp (
    .a  (in_data),
    .b  (out_max),
    .gt (gt)
  );

  assign last_beat = (cnt == len_q - LEN_W'(1));

  // NOTE: state and outputs use non-blocking assignments so every register
  // updates from the same pre-edge values; blocking here would race.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      len_q     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_max   <= '0;
      out_idx   <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              len_q    <= len;
              cnt      <= '0;
              in_ready <= 1'b1;
              busy     <= 1'b1;
              state    <= SCAN;
            end else begin
              err <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (in_valid) begin
            // The first beat seeds the maximum; later beats replace it only on a strict win.
            if (cnt == '0 || gt) begin
              out_max <= in_data;
              out_idx <= cnt;
            end
            if (last_beat) begin
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              cnt <= cnt + LEN_W'(1);
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_max_scan_ctrl.sv
// Directed and randomized bursts checked against a queue-based maximum model.
module tb_max_scan_ctrl;

  localparam int DATA_W = 8;
  localparam int LEN_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_max;
  logic [LEN_W-1:0]  out_idx;
  logic              busy;
  logic              err;

  int total = 0;
  int bad   = 0;
  int beats[$];

  max_scan_ctrl #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
    .out_idx   (out_idx),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: largest value in the burst and the first position holding it.
  task automatic model(output int mx, output int ix);
    mx = -1;
    ix = 0;
    foreach (beats[i]) begin
      if (beats[i] > mx) begin
        mx = beats[i];
        ix = i;
      end
    end
  endtask

  task automatic check_idle_outputs_zero(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_in_ready"},  in_ready,  0);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_err"},       err,       0);
    check({tag, "_out_max"},   out_max,   0);
    check({tag, "_out_idx"},   out_idx,   0);
  endtask

  // Runs one burst from the contents of beats; gap idle cycles precede each
  // beat, out_ready stays low for hold cycles once the result is up.
  task automatic run_burst(input string tag, input int gap, input int hold, input bit mid_start);
    int n, mx, ix;
    n = beats.size();
    model(mx, ix);
    start = 1'b1;
    len   = LEN_W'(n);
    tick();
    start = 1'b0;
    check({tag, "_busy_scan"}, busy, 1);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        tick();
        check({tag, "_gap_ready"}, in_ready, 1);
      end
      check({tag, "_in_ready"}, in_ready, 1);
      in_valid = 1'b1;
      in_data  = DATA_W'(beats[i]);
      if (mid_start && i == 0) begin
        start = 1'b1;
        len   = LEN_W'(2);
      end
      tick();
      start    = 1'b0;
      in_valid = 1'b0;
      if (i < n - 1) check({tag, "_early_valid"}, out_valid, 0);
    end
    check({tag, "_out_valid"}, out_valid, 1);
    check({tag, "_out_max"},   out_max,   mx);
    check({tag, "_out_idx"},   out_idx,   ix);
    check({tag, "_in_ready_done"}, in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      tick();
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_max"},   out_max,   mx);
      check({tag, "_hold_idx"},   out_idx,   ix);
    end
    out_ready = 1'b1;
    start     = 1'b1;
    len       = LEN_W'(3);
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    check({tag, "_drop_valid"}, out_valid, 0);
    check({tag, "_idle_busy"},  busy,      0);
    check({tag, "_idle_ready"}, in_ready,  0);
    tick();
    check({tag, "_keep_max"}, out_max, mx);
    check({tag, "_keep_idx"}, out_idx, ix);
    check({tag, "_still_idle"}, busy, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #2;
    check_idle_outputs_zero("reset");
    #10 rst_n = 1'b1;
    tick();

    beats = '{10, 20, 30};
    run_burst("t1", 0, 0, 1'b0);

    beats = '{20, 20, 5};
    run_burst("t2_tie", 0, 1, 1'b0);

    beats = '{7};
    run_burst("t3_len1", 0, 0, 1'b0);

    start = 1'b1;
    len   = '0;
    tick();
    start = 1'b0;
    check("t3_err_pulse", err, 1);
    check("t3_err_busy",  busy, 0);
    check("t3_err_ready", in_ready, 0);
    tick();
    check("t3_err_clear", err, 0);

    beats = '{30, 10, 40, 40};
    run_burst("t4_gaps", 2, 5, 1'b0);

    // Abort a five-beat burst after two accepted beats.
    start = 1'b1;
    len   = LEN_W'(5);
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'(50 + i);
      tick();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs_zero("t5_abort");
    #3 rst_n = 1'b1;
    tick();
    check_idle_outputs_zero("t5_after");
    beats = '{3, 9, 1};
    run_burst("t5_restart", 0, 0, 1'b0);

    beats = '{4, 8, 6};
    run_burst("t6_mid_start", 1, 0, 1'b1);

    beats = '{255, 0, 255};
    run_burst("edge_maxval", 0, 0, 1'b0);

    beats = '{};
    for (int i = 0; i < 15; i++) beats.push_back(i);
    run_burst("edge_len15", 0, 0, 1'b0);

    for (int r = 0; r < 30; r++) begin
      int n;
      n = $urandom_range(1, 15);
      beats = '{};
      for (int i = 0; i < n; i++) begin
        if (r % 2 == 0) beats.push_back($urandom_range(0, 7));
        else            beats.push_back($urandom_range(0, 255));
      end
      run_burst("rand", $urandom_range(0, 2), $urandom_range(0, 3), r % 5 == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
